// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared types and constants for the oversampled UART receiver.
//           Holds the receiver state encoding, the rx_err bit positions,
//           the data width and a 2-of-3 majority helper.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS  = 8;

  // Bit positions inside rx_err = {break, parity_err, frame_err}
  localparam int ERR_FRAME  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_BREAK  = 2;
  localparam int ERR_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync
// Purpose : Multi-flop synchronizer for the asynchronous serial line.
//           All stages reset to 1 so an idle (high) line never looks like
//           a start edge when reset is released.
// Ports   : clk   - system clock
//           rst_b - asynchronous active-high reset
//           din   - asynchronous input
//           dout  - synchronized output
// Rev     : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_os
// Purpose : Oversampling UART receiver with one-entry holding register.
//           Each bit is sampled three times around its centre and decided
//           by 2-of-3 majority. Supports optional parity, one or two stop
//           bits, break detection and overrun signalling.
// Ports   : clk, rst_b            - clock, async active-high reset
//           cfg_div               - clk cycles per bit (4..65535)
//           cfg_rxen              - receiver enable
//           cfg_nstop             - 0: one stop bit, 1: two stop bits
//           cfg_paren/cfg_parodd  - parity present / odd parity
//           uart_rxd              - serial line, idle high
//           rx_valid/rx_ready     - holding register handshake
//           rx_data               - received byte
//           rx_err                - {break, parity_err, frame_err}
//           rx_overrun            - pulse when a completed frame is dropped
// Rev     : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [15:0]          cfg_div,
  input  logic                 cfg_rxen,
  input  logic                 cfg_nstop,
  input  logic                 cfg_paren,
  input  logic                 cfg_parodd,
  input  logic                 uart_rxd,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [ERR_W-1:0]     rx_err,
  output logic                 rx_overrun
);

  logic                 w_rxs;
  logic                 r_rxs_prev;
  rx_state_t            r_state;
  logic [15:0]          r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_par_bit;
  logic                 r_par_err;

  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic [ERR_W-1:0]     r_err;
  logic                 r_overrun;

  logic [15:0]          w_mid;
  logic [15:0]          w_mid_m1;
  logic [15:0]          w_mid_p1;
  logic [15:0]          w_last;
  logic                 w_wrap;
  logic                 w_dec;
  logic                 w_bit;
  logic                 w_fall;
  logic                 w_stop1_done;
  logic                 w_complete;
  logic                 w_break;
  logic [ERR_W-1:0]     w_err;

  uart_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .din   (uart_rxd),
    .dout  (w_rxs)
  );

  // cfg_div >= 4 keeps mid-1 >= 1 and mid+1 <= cfg_div-1, so all three
  // sample points lie inside one bit period.
  assign w_mid    = {1'b0, cfg_div[15:1]};
  assign w_mid_m1 = w_mid - 16'd1;
  assign w_mid_p1 = w_mid + 16'd1;
  assign w_last   = cfg_div - 16'd1;
  assign w_wrap   = (r_cnt == w_last);
  assign w_dec    = (r_cnt == w_mid_p1);
  // Third vote is the live synchronized value at the decision cycle.
  assign w_bit    = majority3(r_s0, r_s1, w_rxs);
  assign w_fall   = r_rxs_prev & ~w_rxs;

  // A single-stop frame, or a two-stop frame whose first stop bit is bad,
  // finishes at the STOP1 decision instead of running into STOP2.
  assign w_stop1_done = (r_state == ST_STOP1) && w_dec && (!cfg_nstop || !w_bit);
  assign w_complete   = cfg_rxen &&
                        (w_stop1_done || ((r_state == ST_STOP2) && w_dec));

  assign w_break = (r_shift == '0) && (!cfg_paren || !r_par_bit) && !w_bit;

  always_comb begin
    w_err             = '0;
    w_err[ERR_FRAME]  = ~w_bit;
    w_err[ERR_PARITY] = r_par_err;
    w_err[ERR_BREAK]  = w_break;
  end

  // --------------------------------------------------------------------------
  // Receive state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_par_bit  <= 1'b0;
      r_par_err  <= 1'b0;
      r_rxs_prev <= 1'b1;
    end else begin
      r_rxs_prev <= w_rxs;
      if (!cfg_rxen) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        if (r_cnt == w_mid_m1) r_s0 <= w_rxs;
        if (r_cnt == w_mid)    r_s1 <= w_rxs;
        r_cnt <= w_wrap ? 16'd0 : r_cnt + 16'd1;

        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_fall) begin
              r_state   <= ST_START;
              r_idx     <= '0;
              r_par_bit <= 1'b0;
              r_par_err <= 1'b0;
            end
          end
          ST_START: begin
            if (w_dec && w_bit) begin
              // Start bit did not hold low through its centre: glitch.
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_wrap) begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_dec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (w_wrap) begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'(DATA_BITS - 1)) begin
                r_state <= cfg_paren ? ST_PARITY : ST_STOP1;
              end
            end
          end
          ST_PARITY: begin
            if (w_dec) begin
              r_par_bit <= w_bit;
              r_par_err <= ((^r_shift) ^ w_bit) != cfg_parodd;
            end
            if (w_wrap) r_state <= ST_STOP1;
          end
          ST_STOP1: begin
            if (w_stop1_done) begin
              r_state <= w_bit ? ST_IDLE : ST_WAIT_HIGH;
              r_cnt   <= '0;
            end else if (w_wrap) begin
              r_state <= ST_STOP2;
            end
          end
          ST_STOP2: begin
            if (w_dec) begin
              r_state <= w_bit ? ST_IDLE : ST_WAIT_HIGH;
              r_cnt   <= '0;
            end
          end
          ST_WAIT_HIGH: begin
            // Hold off after a framing error (e.g. break) until the line
            // returns high, so a long low is reported only once.
            r_cnt <= '0;
            if (w_rxs) r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Holding register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        // A consumer accepting in the same cycle frees the slot.
        if (!r_valid || rx_ready) begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
          r_err   <= w_err;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid   = r_valid;
  assign rx_data    = r_data;
  assign rx_err     = r_err;
  assign rx_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_os
// Purpose : Directed self-checking bench for uart_rx_os. A line driver
//           serialises frames and pushes the expected {err, data} into a
//           queue; a monitor collects accepted words; the main sequence pops
//           and compares them.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [15:0] cfg_div;
  logic        cfg_rxen;
  logic        cfg_nstop;
  logic        cfg_paren;
  logic        cfg_parodd;
  logic        uart_rxd;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic [2:0]  rx_err;
  logic        rx_overrun;

  uart_rx_os #(
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cfg_div    (cfg_div),
    .cfg_rxen   (cfg_rxen),
    .cfg_nstop  (cfg_nstop),
    .cfg_paren  (cfg_paren),
    .cfg_parodd (cfg_parodd),
    .uart_rxd   (uart_rxd),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  int          got_cyc_q[$];
  int          ovr_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          start_cyc = 0;
  int          last_cyc  = 0;

  // Monitor: record every accepted word and count overrun pulses.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_q.push_back({rx_err, rx_data});
      got_cyc_q.push_back(cyc);
    end
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic bit_out(input logic b, input int nbits);
    uart_rxd = b;
    repeat (nbits * int'(cfg_div)) @(negedge clk);
  endtask

  // Drive one frame and, when a delivery is expected, push the modelled
  // {break, parity_err, frame_err, data}.
  task automatic send(input logic [7:0] d, input bit par_en, input logic par,
                      input logic s1, input logic s2, input bit two_stop,
                      input bit expect_out);
    logic ferr, perr, brk;
    ferr = !s1 || (two_stop && !s2);
    perr = par_en && (((^d) ^ par) != cfg_parodd);
    brk  = (d == 8'h00) && (!par_en || !par) && ferr;
    if (expect_out) exp_q.push_back({brk, perr, ferr, d});
    start_cyc = cyc;
    bit_out(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_out(d[i], 1);
    if (par_en) bit_out(par, 1);
    bit_out(s1, 1);
    if (two_stop && s1) bit_out(s2, 1);
    bit_out(1'b1, 2);
  endtask

  task automatic compare_next(input string tag);
    logic [10:0] g, e;
    int i;
    i = 0;
    while (got_q.size() == 0 && i < 20 * int'(cfg_div)) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("%s_delivered", tag), 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      last_cyc = got_cyc_q.pop_front();
      check($sformatf("%s_data", tag), 32'(g[7:0]), 32'(e[7:0]));
      check($sformatf("%s_err", tag), 32'(g[10:8]), 32'(e[10:8]));
    end
  endtask

  task automatic check_none(input string tag);
    check(tag, 32'(got_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int ov0;
    rst_b      = 1'b1;
    uart_rxd   = 1'b1;
    rx_ready   = 1'b1;
    cfg_rxen   = 1'b1;
    cfg_div    = 16'd868;
    cfg_nstop  = 1'b0;
    cfg_paren  = 1'b0;
    cfg_parodd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",   32'(rx_valid),   32'd0);
    check("rst_data",    32'(rx_data),    32'd0);
    check("rst_err",     32'(rx_err),     32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    rst_b = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 at full divider, with latency window around 9.5 bit times
    send(8'hA5, 0, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("a5");
    lat = last_cyc - start_cyc;
    check("a5_latency", 32'(lat >= 9 * 868 + 434 && lat <= 9 * 868 + 434 + 8), 32'd1);

    cfg_div = 16'd16;
    repeat (4) @(negedge clk);

    // Parity
    cfg_paren = 1'b1;
    send(8'h37, 1, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("par_even_bad");
    send(8'h37, 1, 1'b1, 1'b1, 1'b1, 0, 1);
    compare_next("par_even_ok");
    cfg_parodd = 1'b1;
    send(8'h37, 1, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("par_odd_ok");
    cfg_paren  = 1'b0;
    cfg_parodd = 1'b0;

    // One-clock glitch, then a real frame
    uart_rxd = 1'b0;
    @(negedge clk);
    bit_out(1'b1, 3);
    check_none("glitch");
    send(8'h5A, 0, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("after_glitch");

    // Break: 12 bit times low
    exp_q.push_back({3'b101, 8'h00});
    bit_out(1'b0, 12);
    bit_out(1'b1, 2);
    compare_next("break");
    bit_out(1'b1, 3);
    check_none("break_single");

    // Two stop bits, good and bad second stop
    cfg_nstop = 1'b1;
    send(8'h81, 0, 1'b0, 1'b1, 1'b1, 1, 1);
    compare_next("stop2_ok");
    send(8'h81, 0, 1'b0, 1'b1, 1'b0, 1, 1);
    compare_next("stop2_bad");
    cfg_nstop = 1'b0;

    // Overrun
    rx_ready = 1'b0;
    ov0 = ovr_cnt;
    send(8'h11, 0, 1'b0, 1'b1, 1'b1, 0, 1);
    send(8'h22, 0, 1'b0, 1'b1, 1'b1, 0, 0);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_hold_data", 32'(rx_data), 32'h11);
    check("ovr_hold_err", 32'(rx_err), 32'd0);
    check("ovr_pulses", 32'(ovr_cnt - ov0), 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    compare_next("ovr_first");
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    check_none("ovr_dropped");

    // Receiver disabled mid-frame
    bit_out(1'b0, 4);
    uart_rxd = 1'b1;
    cfg_rxen = 1'b0;
    repeat (5) @(negedge clk);
    cfg_rxen = 1'b1;
    bit_out(1'b1, 12);
    check_none("rxen_abort");
    send(8'hC3, 0, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("after_rxen");

    // Reset mid-frame
    bit_out(1'b0, 4);
    uart_rxd = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    rst_b = 1'b0;
    bit_out(1'b1, 12);
    check_none("rst_abort");
    send(8'h3C, 0, 1'b0, 1'b1, 1'b1, 0, 1);
    compare_next("after_rst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the uart_rxd synchronizer (≥2).
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst_b  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port cfg_div  in  16  clk cycles per bit; legal range 4..65535.
REQ-005 SHALL have port cfg_rxen  in  1  receiver enable.
REQ-006 SHALL have port cfg_nstop  in  1  0 = one stop bit, 1 = two stop bits.
REQ-007 SHALL have port cfg_paren  in  1  parity bit present after data.
REQ-008 SHALL have port cfg_parodd  in  1  1 = odd parity, 0 = even.
REQ-009 SHALL have port uart_rxd  in  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_valid  out  1  holding register full.
REQ-011 SHALL have port rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
REQ-012 SHALL have port rx_data  out  8  received byte, LSB first on line.
REQ-013 SHALL have port rx_err  out  3  {break, parity_err, frame_err}, qualified by rx_valid.
REQ-014 SHALL have port rx_overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL synchronize uart_rxd through SYNC_STAGES flops reset to 1; all decisions use the synchronized value (rxs).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
REQ-017 SHALL run a bit counter cnt 0..cfg_div-1, cleared on each state entry and on wrap; mid = cfg_div>>1.
REQ-018 SHALL sample rxs at cnt = mid-1, mid, mid+1 and take the bit as 2-of-3 majority, decided at cnt = mid+1.
REQ-019 IDLE->START when cfg_rxen=1 and rxs falls 1->0.
REQ-020 START: decided bit 1 -> IDLE (false start, no output); 0 -> DATA at counter wrap.
REQ-021 DATA: shift 8 bits LSB first, 3-bit index; after bit 7 wrap -> PARITY if cfg_paren else STOP1.
REQ-022 PARITY: parity_err = (XOR of data ^ parity bit) != cfg_parodd; -> STOP1 at wrap.
REQ-023 STOP1: frame_err = decided bit 0; -> STOP2 at wrap if cfg_nstop & !frame_err, else complete at decision cycle.
REQ-024 STOP2: frame_err = decided bit 0; complete at decision cycle.
REQ-025 break SHALL be flagged when data = 0x00, parity bit (if present) 0, and frame_err = 1.
REQ-026 On completion, next state SHALL be WAIT_HIGH if frame_err else IDLE; WAIT_HIGH -> IDLE when rxs = 1.
REQ-027 Completed frame SHALL load rx_data/rx_err and set rx_valid on the next cycle (latency 1 clk from decision cycle).
REQ-028 Load when rx_valid = 0 or rx_ready = 1 in the same cycle; no overrun on simultaneous accept and load.
REQ-029 If rx_valid = 1 and rx_ready = 0 at load: keep old contents, pulse rx_overrun one cycle.
REQ-030 rx_valid SHALL clear on accept without concurrent load.
REQ-031 cfg_rxen = 0 SHALL force IDLE and cnt = 0 next cycle, discarding a partial frame; holding register unaffected.
REQ-032 cfg_* changes mid-frame are unsupported; behaviour is defined only for static config.

Reset
REQ-033 On rst_b: state IDLE, cnt 0, synchronizer 1s, rx_valid 0, rx_data 0x00, rx_err 0, rx_overrun 0.
REQ-034 Reset mid-frame SHALL abandon the frame; no output after release until a new falling edge.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum, the rx_err bit-index localparams, and DATA_BITS = 8.
REQ-036 Synchronizer SHALL be sub-module uart_sync (parameter SYNC_STAGES, reset value 1).

Verification
REQ-037 cfg_div=868, 8N1, drive 0xA5 -> rx_valid with rx_data=0xA5, rx_err=0, ~9.5 bit times after the start edge.
REQ-038 cfg_paren=1, cfg_parodd=0, drive 0x37 with parity bit 0 -> rx_data=0x37, rx_err=3'b010.
REQ-039 1-clk low glitch on idle line -> no rx_valid; a following 0x5A frame is received correctly.
REQ-040 Line low 12 bit times then high -> one frame rx_data=0x00, rx_err=3'b101; no second frame until a new edge after high.
REQ-041 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once; raise rx_ready -> rx_valid drops.
REQ-042 Drop cfg_rxen in DATA, restore, send 0xC3 -> only 0xC3 delivered; assert rst_b mid-frame -> no output.
